// File: rtl/my_mod_gen_v1.sv
// Square-wave modulation generator with serrodyne ramp feedback for the phase-modulator DAC.
// Emits alternating LOW/HIGH half-periods, a trigger at each half start and a saturated DAC code.
module my_mod_gen_v1 #(
  parameter int DAC_BIT    = 16,
  parameter int RAMP_SHIFT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_status,
  input  logic [31:0]               i_freq_cnt,
  input  logic signed [31:0]        i_mod_high,
  input  logic signed [31:0]        i_mod_low,
  input  logic signed [31:0]        i_ramp_step,
  input  logic                      i_ramp_en,
  output logic signed [DAC_BIT-1:0] o_dac,
  output logic                      o_trig,
  output logic                      o_phase,
  output logic signed [31:0]        o_ramp,
  output logic [3:0]                o_cstate
);

  localparam logic [3:0] ST_RST   = 4'd0;
  localparam logic [3:0] ST_LOAD  = 4'd1;
  localparam logic [3:0] ST_RUN_L = 4'd2;
  localparam logic [3:0] ST_RUN_H = 4'd3;

  localparam logic signed [32:0] SAT_HI = (33'sd1 <<< (DAC_BIT - 1)) - 33'sd1;
  localparam logic signed [32:0] SAT_LO = -(33'sd1 <<< (DAC_BIT - 1));

  logic [3:0]         cstate;
  logic [31:0]        cnt;
  logic [31:0]        reload;
  logic signed [31:0] ramp_upd;

  assign reload   = ((i_freq_cnt < 32'd2) ? 32'd2 : i_freq_cnt) - 32'd1;
  assign ramp_upd = i_ramp_en ? (o_ramp + i_ramp_step) : o_ramp;
  assign o_cstate = cstate;

  function automatic logic signed [DAC_BIT-1:0] dac_sat(input logic signed [31:0] level,
                                                        input logic signed [31:0] rampv);
    logic signed [31:0] shifted;
    logic signed [32:0] sum;
    shifted = rampv >>> RAMP_SHIFT;
    sum     = {level[31], level} + {shifted[31], shifted};
    if (sum > SAT_HI)      return SAT_HI[DAC_BIT-1:0];
    else if (sum < SAT_LO) return SAT_LO[DAC_BIT-1:0];
    else                   return sum[DAC_BIT-1:0];
  endfunction

  // Period and levels are sampled straight from the inputs at each half boundary;
  // the level lives on in o_dac and the period in the reloaded counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cstate  <= ST_RST;
      cnt     <= '0;
      o_ramp  <= '0;
      o_dac   <= '0;
      o_trig  <= 1'b0;
      o_phase <= 1'b0;
    end else if (!i_status) begin
      cstate  <= ST_RST;
      cnt     <= '0;
      o_ramp  <= '0;
      o_dac   <= '0;
      o_trig  <= 1'b0;
      o_phase <= 1'b0;
    end else begin
      case (cstate)
        ST_RST: begin
          cstate  <= ST_LOAD;
          o_trig  <= 1'b0;
          o_phase <= 1'b0;
          o_dac   <= '0;
        end
        ST_LOAD: begin
          cstate  <= ST_RUN_L;
          cnt     <= reload;
          o_trig  <= 1'b1;
          o_phase <= 1'b0;
          o_dac   <= dac_sat(i_mod_low, o_ramp);
        end
        ST_RUN_L: begin
          if (cnt == '0) begin
            cstate  <= ST_RUN_H;
            cnt     <= reload;
            o_trig  <= 1'b1;
            o_phase <= 1'b1;
            o_dac   <= dac_sat(i_mod_high, o_ramp);
          end else begin
            cnt    <= cnt - 32'd1;
            o_trig <= 1'b0;
          end
        end
        ST_RUN_H: begin
          if (cnt == '0) begin
            cstate  <= ST_RUN_L;
            cnt     <= reload;
            o_ramp  <= ramp_upd;
            o_trig  <= 1'b1;
            o_phase <= 1'b0;
            o_dac   <= dac_sat(i_mod_low, ramp_upd);
          end else begin
            cnt    <= cnt - 32'd1;
            o_trig <= 1'b0;
          end
        end
        default: begin
          cstate  <= ST_RST;
          cnt     <= '0;
          o_ramp  <= '0;
          o_dac   <= '0;
          o_trig  <= 1'b0;
          o_phase <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_mod_gen_v1.sv
// Self-checking bench for my_mod_gen_v1: constant vector table, directed corner sequences,
// and randomized stimulus compared against a half-period-level behavioural model.
module tb_my_mod_gen_v1;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_status = 1'b0;
  logic [31:0]        i_freq_cnt = '0;
  logic signed [31:0] i_mod_high = '0;
  logic signed [31:0] i_mod_low = '0;
  logic signed [31:0] i_ramp_step = '0;
  logic               i_ramp_en = 1'b0;
  logic signed [15:0] o_dac;
  logic               o_trig;
  logic               o_phase;
  logic signed [31:0] o_ramp;
  logic [3:0]         o_cstate;

  my_mod_gen_v1 #(.DAC_BIT(16), .RAMP_SHIFT(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_status(i_status), .i_freq_cnt(i_freq_cnt),
    .i_mod_high(i_mod_high), .i_mod_low(i_mod_low), .i_ramp_step(i_ramp_step),
    .i_ramp_en(i_ramp_en), .o_dac(o_dac), .o_trig(o_trig), .o_phase(o_phase),
    .o_ramp(o_ramp), .o_cstate(o_cstate)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 load, 2 running; m_left = cycles remaining in the current half.
  int m_mode = 0;
  bit m_phase = 0, m_trig = 0;
  int m_left = 0;
  int m_ramp = 0;
  int m_dac = 0;

  typedef struct {
    logic [31:0] freq;
    int high;
    int low;
    int exp_half;
    int exp_low;
    int exp_high;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int level, input int r);
    longint s;
    s = longint'(level) + longint'(r >>> 16);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_trig = 0; m_left = 0; m_ramp = 0; m_dac = 0;
  endtask

  task automatic model_step();
    int p;
    p = (i_freq_cnt < 2) ? 2 : int'(i_freq_cnt);
    if (!i_status) model_reset();
    else if (m_mode == 0) begin
      m_mode = 1; m_trig = 0;
    end else if (m_mode == 1) begin
      m_mode = 2; m_phase = 0; m_left = p; m_trig = 1;
      m_dac = sat16(i_mod_low, m_ramp);
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_phase && i_ramp_en) m_ramp = m_ramp + i_ramp_step;
        m_phase = !m_phase;
        m_left  = p;
        m_trig  = 1;
        m_dac   = sat16(m_phase ? i_mod_high : i_mod_low, m_ramp);
      end else m_trig = 0;
    end
  endtask

  task automatic tick();
    int exp_cs;
    model_step();
    @(posedge i_clk);
    #1;
    exp_cs = (m_mode == 2) ? 2 + int'(m_phase) : m_mode;
    chk("dac", o_dac, m_dac);
    chk("trig", o_trig, m_trig);
    chk("phase", o_phase, m_phase);
    chk("ramp", o_ramp, m_ramp);
    chk("cstate", o_cstate, exp_cs);
  endtask

  task automatic wait_trig(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_trig && n < max);
    chk("trig_seen", o_trig, 1);
  endtask

  task automatic start_run(input logic [31:0] f, input int hi, input int lo);
    i_status = 0;
    tick(); tick();
    i_freq_cnt = f; i_mod_high = hi; i_mod_low = lo;
    i_status = 1;
    tick();
    chk("load_cstate", o_cstate, 1);
    chk("load_trig", o_trig, 0);
    tick();
    chk("first_trig", o_trig, 1);
    chk("first_phase", o_phase, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{32'd100, 1000, -1000, 100, -1000, 1000};
    vecs[1] = '{32'd0, 5, -5, 2, -5, 5};
    vecs[2] = '{32'd1, 7, 3, 2, 3, 7};
    vecs[3] = '{32'd2, 40000, -40000, 2, -32768, 32767};
    vecs[4] = '{32'd3, -40000, 32767, 3, 32767, -32768};
    vecs[5] = '{32'd5, 32768, -32769, 5, -32768, 32767};

    #12;
    chk("rst_dac", o_dac, 0);
    chk("rst_trig", o_trig, 0);
    chk("rst_phase", o_phase, 0);
    chk("rst_ramp", o_ramp, 0);
    chk("rst_cstate", o_cstate, 0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1;
    tick();

    for (int v = 0; v < 6; v++) begin
      start_run(vecs[v].freq, vecs[v].high, vecs[v].low);
      chk("vec_low0", o_dac, vecs[v].exp_low);
      wait_trig(300, n);
      chk("vec_half_l", n, vecs[v].exp_half);
      chk("vec_phase_h", o_phase, 1);
      chk("vec_high", o_dac, vecs[v].exp_high);
      wait_trig(300, n);
      chk("vec_half_h", n, vecs[v].exp_half);
      chk("vec_low1", o_dac, vecs[v].exp_low);
    end

    // ramp accumulates once per full period and shifts the LOW level by +1 each time
    i_ramp_step = 32'h0001_0000; i_ramp_en = 1;
    start_run(10, 100, -100);
    for (int k = 1; k <= 4; k++) begin
      wait_trig(50, n);
      chk("ramp_half_l", n, 10);
      wait_trig(50, n);
      chk("ramp_half_h", n, 10);
      chk("ramp_val", o_ramp, k * 65536);
      chk("ramp_dac_low", o_dac, -100 + k);
    end

    // status drop mid HIGH half, then restart
    wait_trig(50, n);
    tick(); tick(); tick();
    chk("drop_pre_phase", o_phase, 1);
    i_status = 0;
    tick();
    chk("drop_dac", o_dac, 0);
    chk("drop_ramp", o_ramp, 0);
    chk("drop_cstate", o_cstate, 0);
    i_status = 1;
    tick();
    chk("reen_cstate_load", o_cstate, 1);
    tick();
    chk("reen_cstate_runl", o_cstate, 2);
    chk("reen_trig", o_trig, 1);
    chk("reen_phase", o_phase, 0);

    // ramp wrap into negative territory
    i_ramp_step = 32'h4000_0000;
    start_run(4, 0, 0);
    wait_trig(20, n); wait_trig(20, n);
    chk("wrap_ramp1", o_ramp, 32'sh4000_0000);
    chk("wrap_dac1", o_dac, 16384);
    wait_trig(20, n);
    chk("wrap_dac_h", o_dac, 16384);
    wait_trig(20, n);
    chk("wrap_ramp2", o_ramp, -64'sd2147483648);
    chk("wrap_dac2", o_dac, -32768);

    // high level plus large ramp saturates
    i_ramp_step = 32'h7530_0000;
    start_run(4, 40000, 0);
    wait_trig(20, n); wait_trig(20, n);
    chk("sat_low", o_dac, 30000);
    wait_trig(20, n);
    chk("sat_high", o_dac, 32767);
    i_ramp_en = 0; i_ramp_step = 0;

    // freq change mid-LOW only affects the next half
    start_run(100, 1, -1);
    for (int i = 0; i < 30; i++) tick();
    i_freq_cnt = 50;
    wait_trig(300, n);
    chk("fchg_cur_half", n + 30, 100);
    wait_trig(300, n);
    chk("fchg_next_half", n, 50);

    // async reset mid-run clears outputs without a clock edge
    start_run(10, 500, -500);
    tick(); tick(); tick();
    #2;
    i_rst_n = 0;
    #1;
    chk("arst_dac", o_dac, 0);
    chk("arst_trig", o_trig, 0);
    chk("arst_phase", o_phase, 0);
    chk("arst_ramp", o_ramp, 0);
    chk("arst_cstate", o_cstate, 0);
    model_reset();
    i_status = 0;
    #2;
    i_rst_n = 1;
    tick();

    // randomized run against the model
    i_status = 1;
    for (int c = 0; c < 4000; c++) begin
      if (i_status) begin
        if ($urandom_range(0, 299) == 0) i_status = 0;
      end else if ($urandom_range(0, 3) == 0) i_status = 1;
      if ($urandom_range(0, 19) == 0) i_freq_cnt = $urandom_range(0, 12);
      if ($urandom_range(0, 9) == 0)
        i_mod_high = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 80000) - 40000;
      if ($urandom_range(0, 9) == 0)
        i_mod_low = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 80000) - 40000;
      if ($urandom_range(0, 29) == 0) i_ramp_step = $urandom;
      if ($urandom_range(0, 29) == 0) i_ramp_en = $urandom_range(0, 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
